fxp64s_norm_ctrl: RTL



---
 rtl/fxp64s_norm_ctrl_pkg.sv | 17 +
 rtl/fxp64s_chunk_penc.sv | 20 ++
 rtl/fxp64s_norm_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/fxp64s_norm_ctrl_pkg.sv
// FXP64S format constants shared by the normalisation controller and the variable shifter.
package fxp64s_norm_ctrl_pkg;

  localparam int unsigned FXP64S_WIDTH   = 64;
  localparam int unsigned FXP64S_ADDR    = 6;   // bits needed to address any bit of a word
  localparam int unsigned FXP64S_SIGN    = 63;
  localparam int unsigned FXP64S_MAG     = 63;  // magnitude width
  localparam int          FXP64S_LSB_POW = -48;
  localparam int unsigned FXP64S_ONE_POS = int'(-FXP64S_LSB_POW);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DONE
  } norm_state_e;

endpackage

// File: rtl/fxp64s_chunk_penc.sv
// Combinational priority encoder: finds the highest set bit of a chunk, indexed from its MSB.
module fxp64s_chunk_penc #(
  parameter int unsigned CHUNK_W = 8,
  parameter int unsigned IDX_W   = $clog2(CHUNK_W)
) (
  input  logic [CHUNK_W-1:0] chunk,
  output logic               hit,
  output logic [IDX_W-1:0]   idx
);

  // Ascending scan so the highest set bit is the last assignment to stick.
  always_comb begin
    hit = |chunk;
    idx = '0;
    for (int i = 0; i < int'(CHUNK_W); i++) begin
      if (chunk[i]) idx = IDX_W'(int'(CHUNK_W) - 1 - i);
    end
  end

endmodule

// File: rtl/fxp64s_norm_ctrl.sv
// Iterative leading-one scanner producing the shift amount/direction that moves the
// leading one of an FXP64S magnitude onto the unity bit.
module fxp64s_norm_ctrl
  import fxp64s_norm_ctrl_pkg::*;
#(
  parameter int unsigned CHUNK_W    = 8,
  parameter int unsigned TARGET_POS = FXP64S_ONE_POS
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [FXP64S_WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [FXP64S_WIDTH-1:0] out_data,
  output logic [FXP64S_WIDTH-1:0] out_shift,
  output logic                    out_shift_sign,
  output logic                    out_zero
);

  localparam int unsigned W      = FXP64S_WIDTH;
  localparam int unsigned NCHUNK = W / CHUNK_W;
  localparam int unsigned K_W    = $clog2(NCHUNK);
  localparam int unsigned IDX_W  = $clog2(CHUNK_W);
  localparam int unsigned POS_W  = FXP64S_ADDR + 1;

  norm_state_e            state_q, state_d;
  logic [K_W-1:0]         k_q, k_d;
  logic [W-1:0]           vec_q, vec_d;
  logic [W-1:0]           data_q, data_d;
  logic [FXP64S_ADDR-1:0] shift_q, shift_d;
  logic                   sign_q, sign_d;
  logic                   zero_q, zero_d;
  logic                   valid_q, valid_d;
  logic                   ready_q, ready_d;

  logic [CHUNK_W-1:0]     chunk_c;
  logic                   hit_c;
  logic [IDX_W-1:0]       idx_c;
  logic [POS_W-1:0]       pos_c;

  // The scan vector is shifted up one chunk per miss, so the current chunk is always at the top.
  assign chunk_c = vec_q[W-1 -: CHUNK_W];

  fxp64s_chunk_penc #(
    .CHUNK_W (CHUNK_W),
    .IDX_W   (IDX_W)
  ) u_penc (
    .chunk (chunk_c),
    .hit   (hit_c),
    .idx   (idx_c)
  );

  assign pos_c = POS_W'(W - 1) - POS_W'(k_q) * POS_W'(CHUNK_W) - POS_W'(idx_c);

  // Next-state and output-register logic.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    vec_d   = vec_q;
    data_d  = data_q;
    shift_d = shift_q;
    sign_d  = sign_q;
    zero_d  = zero_q;
    valid_d = valid_q;
    ready_d = ready_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          vec_d   = {1'b0, in_data[FXP64S_MAG-1:0]};
          k_d     = '0;
          zero_d  = 1'b0;
          ready_d = 1'b0;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (hit_c) begin
          if (pos_c > POS_W'(TARGET_POS)) begin
            sign_d  = 1'b1;
            shift_d = FXP64S_ADDR'(pos_c - POS_W'(TARGET_POS));
          end else begin
            sign_d  = 1'b0;
            shift_d = FXP64S_ADDR'(POS_W'(TARGET_POS) - pos_c);
          end
          valid_d = 1'b1;
          state_d = ST_DONE;
        end else if (k_q == K_W'(NCHUNK - 1)) begin
          zero_d  = 1'b1;
          shift_d = '0;
          sign_d  = 1'b0;
          valid_d = 1'b1;
          state_d = ST_DONE;
        end else begin
          k_d   = k_q + K_W'(1);
          vec_d = vec_q << CHUNK_W;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          valid_d = 1'b0;
          ready_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      vec_q   <= '0;
      data_q  <= '0;
      shift_q <= '0;
      sign_q  <= 1'b0;
      zero_q  <= 1'b0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      vec_q   <= vec_d;
      data_q  <= data_d;
      shift_q <= shift_d;
      sign_q  <= sign_d;
      zero_q  <= zero_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end

  assign in_ready       = ready_q;
  assign out_valid      = valid_q;
  assign out_data       = data_q;
  assign out_shift      = W'(shift_q);
  assign out_shift_sign = sign_q;
  assign out_zero       = zero_q;

endmodule
